// File: rtl/ov7670_power_sequencer.sv
// ov7670_power_sequencer
// Power-up sequencer for the OV7670 camera. It waits for a stable XCLK PLL
// lock, enables XCLK, walks PWDN and RESET through the datasheet power-up
// order, starts the SCCB configuration engine and then reports camera-ready.
// Loss of lock at any point re-runs the whole sequence from IDLE.
//
// Build option:
//   CAM_SEQ_TIMEOUT_EN - when defined, CFG_WAIT is bounded by
//                        CFG_TIMEOUT_CYCLES and a timeout lands in FAULT.
//                        When undefined, CFG_WAIT waits forever and o_Fault
//                        is held at 0.
//
// All outputs are registered from the next-state decode, so each output
// level appears together with the state it belongs to.

module ov7670_power_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int PWDN_CYCLES        = 25000,
  parameter int RESET_LOW_CYCLES   = 250,
  parameter int SETTLE_CYCLES      = 25000,
  parameter int CFG_TIMEOUT_CYCLES = 2500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Pll_Locked,
  input  logic       i_Cfg_Done,
  input  logic       i_Restart,
  output logic       o_Xclk_En,
  output logic       o_Cam_Pwdn,
  output logic       o_Cam_Reset_L,
  output logic       o_Cfg_Start,
  output logic       o_Ready,
  output logic       o_Fault,
  output logic [3:0] o_State
);

  // Counter is sized for the longest interval, timeout included, so the
  // same width serves both builds.
  localparam int MAX_AB  = (LOCK_STABLE_CYCLES > PWDN_CYCLES) ? LOCK_STABLE_CYCLES : PWDN_CYCLES;
  localparam int MAX_CD  = (RESET_LOW_CYCLES > SETTLE_CYCLES) ? RESET_LOW_CYCLES : SETTLE_CYCLES;
  localparam int MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_ALL = (MAX_ABCD > CFG_TIMEOUT_CYCLES) ? MAX_ABCD : CFG_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;

  // A timed state of N cycles exits when the counter reaches N-1.
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PWDN_LAST   = CNT_W'(PWDN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef CAM_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CFG_TO_LAST = CNT_W'(CFG_TIMEOUT_CYCLES - 1);
`endif
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOCK_WAIT = 4'd1,
    ST_PWDN      = 4'd2,
    ST_RST_LOW   = 4'd3,
    ST_RST_WAIT  = 4'd4,
    ST_CFG_START = 4'd5,
    ST_CFG_WAIT  = 4'd6,
    ST_READY     = 4'd7,
    ST_FAULT     = 4'd8
  } state_t;

  // Lock synchroniser: sync_q[1] is the usable lock level.
  logic [1:0]       sync_q;
  logic [1:0]       sync_d;
  logic             lock_s;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             xclk_en_q;
  logic             xclk_en_d;
  logic             pwdn_q;
  logic             pwdn_d;
  logic             reset_l_q;
  logic             reset_l_d;
  logic             cfg_start_q;
  logic             cfg_start_d;
  logic             ready_q;
  logic             ready_d;
  logic             fault_q;
  logic             fault_d;

  // States whose dwell time is measured by the cycle counter.
  function automatic logic is_timed(input state_t s);
    logic timed;
    case (s)
      ST_LOCK_WAIT: timed = 1'b1;
      ST_PWDN:      timed = 1'b1;
      ST_RST_LOW:   timed = 1'b1;
      ST_RST_WAIT:  timed = 1'b1;
`ifdef CAM_SEQ_TIMEOUT_EN
      ST_CFG_WAIT:  timed = 1'b1;
`else
      ST_CFG_WAIT:  timed = 1'b0;
`endif
      default:      timed = 1'b0;
    endcase
    return timed;
  endfunction

  assign lock_s = sync_q[1];

  // Shift the raw PLL lock into the two-flop synchroniser.
  always_comb begin
    sync_d = {sync_q[0], i_Pll_Locked};
  end

  // Next-state decode; lock loss outranks every other condition.
  always_comb begin
    state_d = state_q;
    if ((state_q != ST_IDLE) && !lock_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lock_s) begin
            state_d = ST_LOCK_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOCK_WAIT: begin
          if (cnt_q == LOCK_LAST) begin
            state_d = ST_PWDN;
          end else begin
            state_d = ST_LOCK_WAIT;
          end
        end
        ST_PWDN: begin
          if (cnt_q == PWDN_LAST) begin
            state_d = ST_RST_LOW;
          end else begin
            state_d = ST_PWDN;
          end
        end
        ST_RST_LOW: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_RST_WAIT;
          end else begin
            state_d = ST_RST_LOW;
          end
        end
        ST_RST_WAIT: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_CFG_START;
          end else begin
            state_d = ST_RST_WAIT;
          end
        end
        ST_CFG_START: begin
          // Done is deliberately not looked at while the start pulse is out.
          state_d = ST_CFG_WAIT;
        end
        ST_CFG_WAIT: begin
          // Done is checked first so it wins over a coincident timeout.
          if (i_Cfg_Done) begin
            state_d = ST_READY;
          end else begin
`ifdef CAM_SEQ_TIMEOUT_EN
            if (cnt_q == CFG_TO_LAST) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_CFG_WAIT;
            end
`else
            state_d = ST_CFG_WAIT;
`endif
          end
        end
        ST_READY: begin
          // Restart re-inits the camera but keeps XCLK running.
          if (i_Restart) begin
            state_d = ST_PWDN;
          end else begin
            state_d = ST_READY;
          end
        end
        ST_FAULT: begin
`ifdef CAM_SEQ_TIMEOUT_EN
          if (i_Restart) begin
            state_d = ST_PWDN;
          end else begin
            state_d = ST_FAULT;
          end
`else
          // Unreachable in this build; recover through IDLE.
          state_d = ST_IDLE;
`endif
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Cycle counter: cleared on state entry, runs only in timed states.
  always_comb begin
    cnt_d = CNT_ZERO;
    if (state_d != state_q) begin
      cnt_d = CNT_ZERO;
    end else if (is_timed(state_q)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // Output levels for the state being entered, so they register with it.
  always_comb begin
    xclk_en_d   = 1'b0;
    pwdn_d      = 1'b1;
    reset_l_d   = 1'b0;
    cfg_start_d = 1'b0;
    ready_d     = 1'b0;
    fault_d     = 1'b0;
    case (state_d)
      ST_IDLE, ST_LOCK_WAIT: begin
        xclk_en_d = 1'b0;
        pwdn_d    = 1'b1;
        reset_l_d = 1'b0;
      end
      ST_PWDN: begin
        xclk_en_d = 1'b1;
        pwdn_d    = 1'b1;
        reset_l_d = 1'b0;
      end
      ST_RST_LOW: begin
        xclk_en_d = 1'b1;
        pwdn_d    = 1'b0;
        reset_l_d = 1'b0;
      end
      ST_RST_WAIT, ST_CFG_WAIT: begin
        xclk_en_d = 1'b1;
        pwdn_d    = 1'b0;
        reset_l_d = 1'b1;
      end
      ST_CFG_START: begin
        xclk_en_d   = 1'b1;
        pwdn_d      = 1'b0;
        reset_l_d   = 1'b1;
        cfg_start_d = 1'b1;
      end
      ST_READY: begin
        xclk_en_d = 1'b1;
        pwdn_d    = 1'b0;
        reset_l_d = 1'b1;
        ready_d   = 1'b1;
      end
      ST_FAULT: begin
        // Camera parked in power-down with XCLK still running.
        xclk_en_d = 1'b1;
        pwdn_d    = 1'b1;
        reset_l_d = 1'b0;
`ifdef CAM_SEQ_TIMEOUT_EN
        fault_d   = 1'b1;
`else
        fault_d   = 1'b0;
`endif
      end
      default: begin
        xclk_en_d = 1'b0;
        pwdn_d    = 1'b1;
        reset_l_d = 1'b0;
      end
    endcase
  end

  // State, counter, synchroniser and output registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_q      <= 2'b00;
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      xclk_en_q   <= 1'b0;
      pwdn_q      <= 1'b1;
      reset_l_q   <= 1'b0;
      cfg_start_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      xclk_en_q   <= xclk_en_d;
      pwdn_q      <= pwdn_d;
      reset_l_q   <= reset_l_d;
      cfg_start_q <= cfg_start_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign o_Xclk_En     = xclk_en_q;
  assign o_Cam_Pwdn    = pwdn_q;
  assign o_Cam_Reset_L = reset_l_q;
  assign o_Cfg_Start   = cfg_start_q;
  assign o_Ready       = ready_q;
  assign o_Fault       = fault_q;
  assign o_State       = state_q;

endmodule

// File: doc/ov7670_power_sequencer.md
Name: ov7670_power_sequencer

Overview:
- Sits directly downstream of the XCLK PLL stage and consumes its `locked` output.
- Waits for a stable PLL lock, then enables XCLK to the OV7670.
- Drives the camera's PWDN and RESET pins through the datasheet power-up order, then launches the SCCB register configuration engine.
- Reports camera-ready to the capture/VGA path and re-runs the whole sequence whenever lock is lost.

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock-high cycles required before the sequence starts.
- PWDN_CYCLES, 25000: cycles PWDN is held high with XCLK running (1 ms at 25 MHz).
- RESET_LOW_CYCLES, 250: cycles RESET is held low after PWDN is released.
- SETTLE_CYCLES, 25000: cycles after RESET release before SCCB access is allowed.
- CFG_TIMEOUT_CYCLES, 2500000: maximum wait for i_Cfg_Done. Used only with CAM_SEQ_TIMEOUT_EN.

Ports:
- i_Clk  input  1  system clock, 25 MHz board clock.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_Pll_Locked  input  1  PLL lock from the XCLK generator; asynchronous to i_Clk.
- i_Cfg_Done  input  1  SCCB config engine finished; level or pulse.
- i_Restart  input  1  single-cycle request to re-initialise the camera.
- o_Xclk_En  output  1  gate enable for XCLK to the camera pin.
- o_Cam_Pwdn  output  1  OV7670 PWDN, active-high.
- o_Cam_Reset_L  output  1  OV7670 RESET, active-low.
- o_Cfg_Start  output  1  one-cycle start pulse to the SCCB config engine.
- o_Ready  output  1  camera powered and configured.
- o_Fault  output  1  configuration timeout (optional feature).
- o_State  output  4  current state encoding, for debug.

Behaviour:
Reset and clocking
- Single clock i_Clk; asynchronous active-low reset i_Rst_L, released synchronously by the upstream reset logic.
- Reset values: state IDLE, counter 0, o_Xclk_En=0, o_Cam_Pwdn=1, o_Cam_Reset_L=0, o_Cfg_Start=0, o_Ready=0, o_Fault=0, o_State=0.
- All outputs are registered. Each output changes in the cycle after the state transition that defines it.

Lock synchroniser
- i_Pll_Locked passes through a 2-flop synchroniser to give lock_s (2-cycle latency).

Timed states
- The cycle counter clears on every state entry.
- A timed state lasting N cycles exits when the counter equals N-1, so the state occupies exactly N cycles.
- Counter width is $clog2 of the largest parameter, plus 1.

States, with encodings and output levels:
- IDLE(0): Pwdn=1, Reset_L=0, Xclk_En=0. Go to LOCK_WAIT when lock_s=1.
- LOCK_WAIT(1): same outputs. Any cycle with lock_s=0 returns to IDLE. After LOCK_STABLE_CYCLES consecutive high cycles, go to PWDN.
- PWDN(2): Xclk_En=1, Pwdn=1, Reset_L=0, for PWDN_CYCLES.
- RST_LOW(3): Pwdn=0, Reset_L=0, for RESET_LOW_CYCLES.
- RST_WAIT(4): Reset_L=1, for SETTLE_CYCLES.
- CFG_START(5): o_Cfg_Start=1 for exactly one cycle. i_Cfg_Done is ignored in this state.
- CFG_WAIT(6): go to READY on the first cycle i_Cfg_Done=1.
- READY(7): o_Ready=1. i_Restart=1 goes to PWDN (full camera re-init; XCLK stays enabled).
- FAULT(8): see Optional Feature.

Global rules
- lock_s=0 in any state other than IDLE forces IDLE on the next cycle. All outputs return to their reset levels, including o_Ready=0 and o_Fault=0.
- Lock loss has priority over i_Restart, i_Cfg_Done and timeout.
- i_Restart is ignored in states 0–6.
- i_Cfg_Done and timeout in the same cycle: done wins, go to READY.
- o_Ready falls in the cycle after leaving READY.
- Reset asserted mid-sequence: immediate asynchronous return to the reset values.

Optional Feature:
- Macro: CAM_SEQ_TIMEOUT_EN.
- Defined:
  - The CFG_WAIT counter runs. If CFG_TIMEOUT_CYCLES elapse without i_Cfg_Done, go to FAULT.
  - FAULT outputs: o_Fault=1, Pwdn=1, Reset_L=0, Xclk_En=1, o_Ready=0.
  - i_Restart leaves FAULT to PWDN and clears o_Fault.
  - Lock loss leaves FAULT to IDLE.
- Undefined:
  - CFG_WAIT waits indefinitely and FAULT is unreachable.
  - o_Fault is tied to 0; CFG_TIMEOUT_CYCLES is unused.

Test Plan:
- Bench parameters for all scenarios: LOCK=8, PWDN=4, RST_LOW=3, SETTLE=5, TIMEOUT=20.
- Nominal power-up: lock high from cycle 0, i_Cfg_Done pulsed 6 cycles after o_Cfg_Start -> o_State walks 0,1,2,3,4,5,6,7. Pwdn high exactly 4 Xclk_En cycles; Reset_L low 3 further cycles; o_Cfg_Start is a single 1-cycle pulse 5 cycles after Reset_L rises; o_Ready=1 one cycle after done.
- Lock glitch: lock drops for 1 cycle at LOCK_WAIT count 5 -> return to IDLE; the full 8-cycle count restarts; PWDN is not entered early.
- Lock loss in READY: lock deasserted -> within 2+1 cycles o_Ready=0, Xclk_En=0, Pwdn=1, Reset_L=0, state 0. Relock repeats the full sequence.
- Restart: i_Restart pulse in READY -> state 2 next cycle; Xclk_En stays 1; the sequence completes again with a second o_Cfg_Start pulse. i_Restart pulsed during RST_WAIT has no effect.
- Timeout (CAM_SEQ_TIMEOUT_EN): no i_Cfg_Done -> after 20 cycles in CFG_WAIT, o_Fault=1 and state 8. i_Restart -> o_Fault=0, state 2. Without the macro the bench holds 100 cycles in state 6 with o_Fault=0.
- Async reset mid-RST_LOW: i_Rst_L=0 -> outputs at reset values with no clock edge required.
